uart_ch_reporter: RTL and testbench
===================================

Name: uart_ch_reporter

Overview:
Parametrised successor to the single-value UART sender. On a start pulse it snapshots CH_NUM unsigned channel values. For each enabled channel it converts the value to ASCII decimal and transmits one text line over 8N1 UART. The block sits between the ADC/voltage channel registers and the Basys3 USB-UART TX pin, and reports all 13 voltage channels to a host terminal.

Parameters:
CH_NUM, 13, number of channels (1..99)
DATA_W, 16, width of each channel value
DIGITS, 4, decimal digits sent per value (1..5)
CLK_HZ, 100_000_000, clk frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD (integer division, DIV >= 2)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
in  in  CH_NUM*DATA_W  channel values; channel k = in[k*DATA_W +: DATA_W]
ch_mask  in  CH_NUM  1 = channel reported; sampled together with in
start  in  1  one-cycle request to send a report
tx  out  1  UART serial line, idle high
tick  out  1  one-cycle pulse at the end of every transmitted byte's stop bit
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last byte of a report

Behaviour:
- Reset (rst=0, asynchronous): tx=1, tick=0, busy=0, done=0. FSM goes to IDLE and all counters clear. Reset mid-byte aborts the report immediately with no partial stop bit.
- IDLE: start=1 with busy=0 registers in and ch_mask into a snapshot; busy=1 on the next cycle. start is ignored while busy=1.
- Line format per enabled channel, in ascending index order: two ASCII digits of the channel index ("00".."12"), ':', DIGITS ASCII digits of the value with zero padding, CR (0x0D), LF (0x0A). This is DIGITS+5 bytes per line.
- Clamp: any value >= 10^DIGITS is sent as DIGITS '9' characters.
- FSM states: IDLE -> SEL (find the next enabled channel) -> CONV (sequential double-dabble, DATA_W cycles) -> SEND (byte loop over the line) -> SEL. When no enabled channel remains, SEL -> FIN. FIN pulses done for 1 cycle, drops busy, and returns to IDLE.
- If ch_mask is all zero: done pulses 2 cycles after start, tx stays high, no tick.
- Latency: the first start bit (tx falling edge) occurs no more than DATA_W+4 cycles after the accepted start.
- Byte framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly DIV cycles.
- tick is asserted in the final cycle of the stop bit. The next byte's start bit begins on the following cycle, so there are no idle gaps within a report.
- Between lines, the next line's first start bit begins within DATA_W+2 cycles of the previous LF tick. tx stays high during that gap.
- Snapshot values are stable for the whole report; changes on in/ch_mask during busy have no effect.

Decomposition:
- Package uart_rep_pkg: ASCII constants (ZERO=8'h30, COLON=8'h3A, CR=8'h0D, LF=8'h0A), FSM state encoding, and the clog2 helper function.
- Sub-module uart_tx_byte (params CLK_HZ, BAUD; ports clk, rst, data[7:0], load, tx, tick, ready) handles the baud counter and shift register.
- The bin-to-BCD conversion and line sequencing stay in the top level.

Test Plan:
- Sim params CH_NUM=2, DIGITS=4, CLK_HZ=1_000_000, BAUD=100_000 (DIV=10). ch0=89, ch1=1234, mask=2'b11, start -> tx decodes "00:0089\r\n01:1234\r\n"; 18 tick pulses 100 cycles apart; done 1 cycle after the 18th tick.
- ch0=12345, mask=2'b01 -> "00:9999\r\n" only; 9 ticks; busy low after done.
- mask=2'b00, start -> done exactly 2 cycles later, tx constantly 1, zero ticks.
- start again during byte 3 of a report and change in mid-report -> output identical to an undisturbed report; the second start is ignored.
- rst=0 asynchronously during a data bit of byte 5 -> tx=1, busy=0, tick=0 before the next clk edge. After release, start -> full correct report.
- ch0=0, ch1=65535 with DIGITS=5 -> "00:00000\r\n01:65535\r\n"; bit timing is 10 cycles ±0 on every bit.

Source files
------------

// File: rtl/uart_rep_pkg.sv
// Shared constants, FSM encoding and elaboration-time helpers for the
// multi-channel UART reporter.
package uart_rep_pkg;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    CONV,
    SEND,
    FIN
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A load in the last stop-bit cycle chains the next
// byte with no idle gap between frames.
module uart_tx_byte
  import uart_rep_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       tick,
  output logic       ready
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic             active;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic [9:0]       shreg;
  logic             bit_end;
  logic             last_bit;

  assign bit_end  = (baud_cnt == LAST_CNT);
  assign last_bit = (bit_idx == 4'd9);
  assign tick     = active && bit_end && last_bit;
  assign ready    = !active || (bit_end && last_bit);
  assign tx       = active ? shreg[0] : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   <= 1'b0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      shreg    <= '1;
    end else if (load && ready) begin
      active   <= 1'b1;
      bit_idx  <= '0;
      baud_cnt <= '0;
      shreg    <= {1'b1, data, 1'b0};
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (last_bit) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_ch_reporter.sv
// Snapshots CH_NUM channel values and sends one "NN:dddd\r\n" line per
// enabled channel over UART, converting each value with serial double-dabble.
module uart_ch_reporter
  import uart_rep_pkg::*;
#(
  parameter int CH_NUM = 13,
  parameter int DATA_W = 16,
  parameter int DIGITS = 4,
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM*DATA_W-1:0] in,
  input  logic [CH_NUM-1:0]        ch_mask,
  input  logic                     start,
  output logic                     tx,
  output logic                     tick,
  output logic                     busy,
  output logic                     done
);

  localparam int LINE_LEN = DIGITS + 5;
  localparam int BCD_W    = 4 * DIGITS;
  localparam int CH_W     = clog2(CH_NUM + 1);
  localparam int BI_W     = clog2(LINE_LEN + 1);
  localparam int CC_W     = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
  localparam logic [31:0]     LIMIT     = 32'(pow10(DIGITS));
  localparam logic [BI_W-1:0] LINE_DONE = BI_W'(LINE_LEN);
  localparam logic [CC_W-1:0] CONV_LAST = CC_W'(DATA_W - 1);

  state_t state, state_nxt;

  logic [CH_NUM*DATA_W-1:0] in_s;
  logic [CH_NUM-1:0]        mask_s;
  logic [CH_W-1:0]          scan, cur_ch, found_ch;
  logic                     found, found_clamp;
  logic [DATA_W-1:0]        found_val, bin;
  logic [BCD_W-1:0]         bcd, bcd_adj;
  logic                     clamp;
  logic [CC_W-1:0]          conv_cnt;
  logic [BI_W-1:0]          byte_idx;
  logic [7:0]               tx_data;
  logic                     tx_load, tx_ready, tx_tick, line_end, pick;

  // Lowest enabled channel at or above scan; scan points past the last one sent.
  always_comb begin
    found     = 1'b0;
    found_ch  = '0;
    found_val = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (k >= int'(scan) && mask_s[k]) begin
        found     = 1'b1;
        found_ch  = CH_W'(k);
        found_val = in_s[k*DATA_W +: DATA_W];
      end
    end
  end

  assign found_clamp = (32'(found_val) >= LIMIT);
  assign line_end    = (state == SEND) && (byte_idx == LINE_DONE) && tx_tick;
  assign pick        = found && ((state == SEL) || line_end);
  assign tick        = tx_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // After the LF tick the next channel is chosen directly, skipping SEL,
  // so the inter-line gap is only the conversion time.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SEL;
      SEL:  state_nxt = found ? CONV : FIN;
      CONV: if (conv_cnt == CONV_LAST) state_nxt = SEND;
      SEND: if (line_end) state_nxt = found ? CONV : FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == FIN);
    tx_load = (state == SEND) && (byte_idx != LINE_DONE) && tx_ready;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_s     <= '0;
      mask_s   <= '0;
      scan     <= '0;
      cur_ch   <= '0;
      bin      <= '0;
      bcd      <= '0;
      clamp    <= 1'b0;
      conv_cnt <= '0;
      byte_idx <= '0;
    end else begin
      if (state == IDLE && start) begin
        in_s   <= in;
        mask_s <= ch_mask;
        scan   <= '0;
      end
      if (pick) begin
        cur_ch   <= found_ch;
        scan     <= found_ch + 1'b1;
        bin      <= found_val;
        bcd      <= '0;
        clamp    <= found_clamp;
        conv_cnt <= '0;
        byte_idx <= '0;
      end
      if (state == CONV) begin
        bin      <= bin << 1;
        bcd      <= BCD_W'({bcd_adj, bin[DATA_W-1]});
        conv_cnt <= conv_cnt + 1'b1;
      end
      if (tx_load) byte_idx <= byte_idx + 1'b1;
    end
  end

  // Only the lower DIGITS BCD digits are kept; larger values are clamped anyway.
  always_comb begin
    tx_data = LF;
    if (byte_idx == BI_W'(0))                tx_data = ZERO + 8'(cur_ch / 10);
    else if (byte_idx == BI_W'(1))           tx_data = ZERO + 8'(cur_ch % 10);
    else if (byte_idx == BI_W'(2))           tx_data = COLON;
    else if (byte_idx == BI_W'(DIGITS + 3))  tx_data = CR;
    else if (byte_idx == BI_W'(DIGITS + 4))  tx_data = LF;
    else begin
      for (int j = 0; j < DIGITS; j++) begin
        if (byte_idx == BI_W'(j + 3))
          tx_data = clamp ? NINE : ZERO + {4'h0, bcd[4*(DIGITS-1-j) +: 4]};
      end
    end
  end

  uart_tx_byte #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (tx_data),
    .load (tx_load),
    .tx   (tx),
    .tick (tx_tick),
    .ready(tx_ready)
  );

endmodule

// File: tb/tb_uart_ch_reporter.sv
// Bench for uart_ch_reporter: decodes the serial line independently and
// compares against text lines formatted straight from the channel values.
module tb_uart_ch_reporter;

  localparam int DATA_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_bus = '0;
  logic [1:0]  ch_mask = '0;
  logic        start = 1'b0;
  logic        tx, tick, busy, done;

  int errors = 0;
  int checks = 0;

  uart_ch_reporter #(
    .CH_NUM(2),
    .DATA_W(DATA_W),
    .DIGITS(4),
    .CLK_HZ(1_000_000),
    .BAUD  (100_000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in_bus),
    .ch_mask(ch_mask),
    .start  (start),
    .tx     (tx),
    .tick   (tick),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Serial line decoder: 10 cycles per bit, every cycle of a bit must agree.
  logic [7:0] rx_q[$];
  bit         rx_active = 0;
  bit         rx_bad;
  int         rx_cyc;
  int         bit_no;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (!rst) begin
      rx_active = 0;
    end else begin
      if (rx_active) begin
        rx_cyc++;
      end else begin
        if (tick === 1'b1) begin
          checks++; errors++;
          $display("[TB] FAIL stray_tick: tick=1 while line idle, required 0");
        end
        if (tx === 1'b0) begin
          rx_active = 1; rx_cyc = 0; rx_bad = 0; rx_byte = '0;
        end
      end
      if (rx_active) begin
        bit_no = rx_cyc / 10;
        if (bit_no == 0 && tx !== 1'b0) rx_bad = 1;
        if (bit_no == 9 && tx !== 1'b1) rx_bad = 1;
        if (bit_no >= 1 && bit_no <= 8) begin
          if (rx_cyc % 10 == 0) rx_byte[bit_no-1] = tx;
          else if (tx !== rx_byte[bit_no-1]) rx_bad = 1;
        end
        if (rx_cyc != 99 && tick === 1'b1) rx_bad = 1;
        if (rx_cyc == 99) begin
          checks++;
          if (rx_bad || tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame: byte=%02h bad_bits=%0d tick_at_stop_end=%b, required clean frame with tick=1", rx_byte, rx_bad, tick);
          end
          rx_q.push_back(rx_byte);
          rx_active = 0;
        end
      end
    end
  end

  function automatic string model(input int v0, input int v1, input logic [1:0] m);
    string s;
    s = "";
    if (m[0]) s = {s, $sformatf("%02d:%04d\r\n", 0, (v0 > 9999) ? 9999 : v0)};
    if (m[1]) s = {s, $sformatf("%02d:%04d\r\n", 1, (v1 > 9999) ? 9999 : v1)};
    return s;
  endfunction

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 16'($urandom_range(0, 9999));
      1: return 16'($urandom_range(10000, 65535));
      2: return 16'($urandom_range(0, 99));
      default: begin
        case ($urandom_range(0, 3))
          0: return 16'd9999;
          1: return 16'd10000;
          2: return 16'd0;
          default: return 16'd65535;
        endcase
      end
    endcase
  endfunction

  task automatic run_report(input logic [15:0] v0, input logic [15:0] v1,
                            input logic [1:0] m, input bit disturb);
    string exp;
    int n, nticks, last_tick, first_fall, gap_from, lowseen, mism;
    bit got_done, disturbed, spacing_bad, gap_bad, quiet_bad;
    exp = model(int'(v0), int'(v1), m);
    rx_q.delete();
    n = 0; nticks = 0; last_tick = -1; first_fall = -1; gap_from = -1; lowseen = 0;
    got_done = 0; disturbed = 0; spacing_bad = 0; gap_bad = 0; quiet_bad = 0;
    @(negedge clk);
    in_bus = {v1, v0}; ch_mask = m; start = 1'b1;
    while (n < 5000 && !got_done) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("[TB] FAIL busy_after_start: got %b, required 1", busy);
        end
      end
      if (disturb && !disturbed && nticks == 2) begin
        start = 1'b1; in_bus = $urandom; ch_mask = 2'($urandom); disturbed = 1;
      end
      if (tx === 1'b0) begin
        lowseen++;
        if (first_fall < 0) first_fall = n;
        if (gap_from >= 0) begin
          if (n - gap_from > DATA_W + 2) gap_bad = 1;
          gap_from = -1;
        end
      end
      if (tick === 1'b1) begin
        nticks++;
        if (last_tick >= 0 && (nticks - 1) % 9 != 0 && n - last_tick != 100) spacing_bad = 1;
        if (nticks % 9 == 0) gap_from = n;
        last_tick = n;
      end
      if (done === 1'b1) got_done = 1;
    end
    checks++;
    if (!got_done) begin
      errors++; $display("[TB] FAIL done_timeout: no done within %0d cycles", n);
    end
    checks++;
    if (nticks != 9 * $countones(m)) begin
      errors++; $display("[TB] FAIL tick_count: got %0d, required %0d", nticks, 9 * $countones(m));
    end
    checks++;
    if (m != 2'b00) begin
      if (n != last_tick + 1) begin
        errors++; $display("[TB] FAIL done_after_tick: done at %0d, last tick at %0d, required 1 cycle later", n, last_tick);
      end
    end else if (n != 2 || lowseen != 0) begin
      errors++; $display("[TB] FAIL empty_report: done at %0d tx_low_cycles=%0d, required 2 and 0", n, lowseen);
    end
    if (m != 2'b00) begin
      checks++;
      if (first_fall < 1 || first_fall > DATA_W + 4) begin
        errors++; $display("[TB] FAIL first_start_latency: got %0d, required 1..%0d", first_fall, DATA_W + 4);
      end
      checks++;
      if (spacing_bad || gap_bad) begin
        errors++; $display("[TB] FAIL byte_timing: tick_spacing_bad=%0d line_gap_bad=%0d, required 0 0", spacing_bad, gap_bad);
      end
    end
    mism = 0;
    if (rx_q.size() != exp.len()) mism = -1;
    else for (int i = 0; i < exp.len(); i++) if (rx_q[i] !== exp[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("[TB] FAIL text: got %0d bytes (%0d differ), required %0d bytes for v0=%0d v1=%0d mask=%b", rx_q.size(), mism, exp.len(), v0, v1, m);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_after_done: got %b, required 0", busy);
    end
    if (disturb) begin
      repeat (200) begin
        @(negedge clk);
        if (busy !== 1'b0 || tick === 1'b1 || tx !== 1'b1) quiet_bad = 1;
      end
      checks++;
      if (quiet_bad) begin
        errors++; $display("[TB] FAIL ignored_start: activity after done, required idle line");
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 4;
    if (tx !== 1'b1)   begin errors++; $display("[TB] FAIL reset_tx: got %b, required 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
    if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %b, required 0", tick); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    run_report(16'd89, 16'd1234, 2'b11, 0);
    run_report(16'd12345, 16'd777, 2'b01, 0);
  endtask

  task automatic test_empty_mask();
    run_report(rand_val(), rand_val(), 2'b00, 0);
  endtask

  task automatic test_boundaries();
    run_report(16'd0, 16'd65535, 2'b11, 0);
    run_report(16'd9999, 16'd10000, 2'b11, 0);
    run_report(16'd5, 16'd100, 2'b10, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_report(rand_val(), rand_val(), 2'($urandom_range(1, 3)), 0);
  endtask

  task automatic test_ignore_start();
    run_report(rand_val(), rand_val(), 2'b11, 1);
  endtask

  task automatic test_reset_midbyte();
    int n, nticks;
    n = 0; nticks = 0;
    @(negedge clk);
    in_bus = {16'd4321, 16'd765}; ch_mask = 2'b11; start = 1'b1;
    while (nticks < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (tick === 1'b1) nticks++;
    end
    checks++;
    if (nticks != 4) begin
      errors++; $display("[TB] FAIL reset_setup: got %0d ticks, required 4", nticks);
    end
    repeat (35) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks += 4;
    if (tx !== 1'b1)   begin errors++; $display("[TB] FAIL async_reset_tx: got %b, required 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b, required 0", busy); end
    if (tick !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_tick: got %b, required 0", tick); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_done: got %b, required 0", done); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_report(rand_val(), rand_val(), 2'b11, 0);
  endtask

  initial begin
    $display("[TB] uart_ch_reporter bench start");
    test_reset();
    test_basic();
    test_empty_mask();
    test_boundaries();
    test_random();
    test_ignore_start();
    test_reset_midbyte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
